// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter
// Round-robin sharing of a single AXI4 read port (AR + R channels) among
// NUM_MASTERS requesters. Only one burst is in flight at a time. R beats are
// routed back to the granted requester, and RLAST is checked against the
// captured burst length.
// Optional build macro AXI4_RD_ARB_BURST_CHECK_EN: when it is defined,
// illegal requests are not forwarded downstream. Instead, the arbiter answers
// them locally with SLVERR beats.
module axi4_rd_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         s_arvalid,
  output logic [NUM_MASTERS-1:0]         s_arready,
  input  logic [NUM_MASTERS*ADDR_W-1:0]  s_araddr,
  input  logic [NUM_MASTERS*8-1:0]       s_arlen,
  input  logic [NUM_MASTERS*3-1:0]       s_arsize,
  input  logic [NUM_MASTERS*2-1:0]       s_arburst,
  output logic [NUM_MASTERS-1:0]         s_rvalid,
  input  logic [NUM_MASTERS-1:0]         s_rready,
  output logic [DATA_W-1:0]              s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rlast,
  output logic                           m_arvalid,
  input  logic                           m_arready,
  output logic [ADDR_W-1:0]              m_araddr,
  output logic [7:0]                     m_arlen,
  output logic [2:0]                     m_arsize,
  output logic [1:0]                     m_arburst,
  input  logic                           m_rvalid,
  output logic                           m_rready,
  input  logic [DATA_W-1:0]              m_rdata,
  input  logic [1:0]                     m_rresp,
  input  logic                           m_rlast,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           busy,
  output logic                           rlast_err
);

  localparam int GW = $clog2(NUM_MASTERS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
`ifdef AXI4_RD_ARB_BURST_CHECK_EN
  localparam logic [1:0] ST_ERR      = 2'd3;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [2:0] MAX_SIZE    = 3'($clog2(DATA_W/8));
`endif

  logic [1:0]        state_r;
  logic [GW-1:0]     rr_ptr_r;
  logic [GW-1:0]     grant_id_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        len_r;
  logic [2:0]        size_r;
  logic [1:0]        burst_r;
  logic [7:0]        beat_cnt_r;
  logic              rlast_err_r;

  logic              req_found_s;
  logic [GW-1:0]     req_sel_s;
  logic [GW:0]       scan_idx_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [7:0]        req_len_s;
  logic [2:0]        req_size_s;
  logic [1:0]        req_burst_s;
  logic [GW-1:0]     next_ptr_s;
  logic              beat_acc_s;
  logic              len_hit_s;

`ifdef AXI4_RD_ARB_BURST_CHECK_EN
  // Legality of a request:
  //   - reserved burst type is illegal
  //   - WRAP needs 2/4/8/16 beats
  //   - FIXED is limited to 16 beats
  //   - size must not exceed the bus width
  //   - INCR must not cross a 4KB boundary
  function automatic logic burst_legal(input logic [11:0] addr_lo,
                                       input logic [7:0]  len,
                                       input logic [2:0]  size,
                                       input logic [1:0]  burst);
    logic [16:0] end_off;
    logic        bad_type;
    logic        bad_wrap;
    logic        bad_fixed;
    logic        bad_size;
    logic        bad_4k;
    end_off   = {5'd0, addr_lo} + (({9'd0, len} + 17'd1) << size);
    bad_type  = (burst == 2'd3);
    bad_wrap  = (burst == 2'd2) && !((len == 8'd1) || (len == 8'd3) ||
                                     (len == 8'd7) || (len == 8'd15));
    bad_fixed = (burst == 2'd0) && (len > 8'd15);
    bad_size  = (size > MAX_SIZE);
    bad_4k    = (burst == 2'd1) && (end_off > 17'd4096);
    return !(bad_type || bad_wrap || bad_fixed || bad_size || bad_4k);
  endfunction

  logic req_legal_s;
  assign req_legal_s = burst_legal(req_addr_s[11:0], req_len_s, req_size_s, req_burst_s);
`endif

  // Round-robin scan: the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    req_found_s = 1'b0;
    req_sel_s   = '0;
    scan_idx_s  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan_idx_s = {1'b0, rr_ptr_r} + (GW+1)'(k);
      if (scan_idx_s >= (GW+1)'(NUM_MASTERS)) begin
        scan_idx_s = scan_idx_s - (GW+1)'(NUM_MASTERS);
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!req_found_s && s_arvalid[scan_idx_s[GW-1:0]]) begin
        req_found_s = 1'b1;
        req_sel_s   = scan_idx_s[GW-1:0];
      end else begin
        req_found_s = req_found_s;
      end
    end
  end

  assign req_addr_s  = s_araddr[req_sel_s*ADDR_W +: ADDR_W];
  assign req_len_s   = s_arlen[req_sel_s*8 +: 8];
  assign req_size_s  = s_arsize[req_sel_s*3 +: 3];
  assign req_burst_s = s_arburst[req_sel_s*2 +: 2];

  assign next_ptr_s = (grant_id_r == GW'(NUM_MASTERS-1)) ? '0 : (grant_id_r + GW'(1));
  assign beat_acc_s = m_rvalid && s_rready[grant_id_r];
  assign len_hit_s  = (beat_cnt_r == len_r);

  // Burst sequencing, request capture, beat counting and RLAST checking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_id_r  <= '0;
      addr_r      <= '0;
      len_r       <= 8'd0;
      size_r      <= 3'd0;
      burst_r     <= 2'd0;
      beat_cnt_r  <= 8'd0;
      rlast_err_r <= 1'b0;
    end else begin
      rlast_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_found_s) begin
            addr_r     <= req_addr_s;
            len_r      <= req_len_s;
            size_r     <= req_size_s;
            burst_r    <= req_burst_s;
            grant_id_r <= req_sel_s;
            beat_cnt_r <= 8'd0;
`ifdef AXI4_RD_ARB_BURST_CHECK_EN
            state_r    <= req_legal_s ? ST_ADDR : ST_ERR;
`else
            state_r    <= ST_ADDR;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            state_r <= ST_DATA;
          end else begin
            state_r <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (beat_acc_s) begin
            beat_cnt_r  <= beat_cnt_r + 8'd1;
            rlast_err_r <= m_rlast ? !len_hit_s : len_hit_s;
            if (m_rlast) begin
              state_r  <= ST_IDLE;
              rr_ptr_r <= next_ptr_s;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
`ifdef AXI4_RD_ARB_BURST_CHECK_EN
        ST_ERR: begin
          if (s_rready[grant_id_r]) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            if (len_hit_s) begin
              state_r  <= ST_IDLE;
              rr_ptr_r <= next_ptr_s;
            end else begin
              state_r <= ST_ERR;
            end
          end else begin
            state_r <= ST_ERR;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake steering and R-channel routing for the current state.
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'd0;
    s_rlast   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_found_s) begin
          s_arready[req_sel_s] = 1'b1;
        end else begin
          s_arready = '0;
        end
      end
      ST_DATA: begin
        s_rvalid[grant_id_r] = m_rvalid;
        m_rready             = s_rready[grant_id_r];
        s_rdata              = m_rdata;
        s_rresp              = m_rresp;
        s_rlast              = m_rlast;
      end
`ifdef AXI4_RD_ARB_BURST_CHECK_EN
      ST_ERR: begin
        s_rvalid[grant_id_r] = 1'b1;
        s_rresp              = RESP_SLVERR;
        s_rlast              = len_hit_s;
      end
`endif
      default: begin
        s_arready = '0;
      end
    endcase
  end

  assign m_arvalid = (state_r == ST_ADDR);
  assign m_araddr  = addr_r;
  assign m_arlen   = len_r;
  assign m_arsize  = size_r;
  assign m_arburst = burst_r;
  assign grant_id  = grant_id_r;
  assign busy      = (state_r != ST_IDLE);
  assign rlast_err = rlast_err_r;

endmodule

// File: doc/axi4_rd_arbiter.md
Name: axi4_rd_arbiter

Overview:
- Shares one AXI4 read port (AR + R channels) between NUM_MASTERS requesters using round-robin arbitration.
- Serializes traffic: exactly one burst in flight at a time.
- Routes R beats back to the granted requester and checks RLAST against the burst length.
- Sits between DMA/engine read masters and the single memory-controller read port; response and burst encodings are the shared AXI package types (OKAY=0, SLVERR=2, DECERR=3; FIXED=0, INCR=1, WRAP=2).

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 64, data width (power of 2, >=8)

Ports:
clk  in  1  sole clock
rst  in  1  reset; asynchronous, active-high
s_arvalid  in  NUM_MASTERS  per-requester AR valid
s_arready  out  NUM_MASTERS  per-requester AR ready
s_araddr  in  NUM_MASTERS*ADDR_W  flattened AR addresses, requester i at [i*ADDR_W +: ADDR_W]
s_arlen  in  NUM_MASTERS*8  flattened burst lengths (beats = len+1)
s_arsize  in  NUM_MASTERS*3  flattened sizes (bytes = 2**size)
s_arburst  in  NUM_MASTERS*2  flattened burst types
s_rvalid  out  NUM_MASTERS  per-requester R valid
s_rready  in  NUM_MASTERS  per-requester R ready
s_rdata  out  DATA_W  R data, broadcast to all requesters
s_rresp  out  2  R response, broadcast
s_rlast  out  1  R last, broadcast
m_arvalid/m_arready  out/in  1/1  downstream AR handshake
m_araddr, m_arlen, m_arsize, m_arburst  out  ADDR_W, 8, 3, 2  downstream AR fields
m_rvalid/m_rready  in/out  1/1  downstream R handshake
m_rdata, m_rresp, m_rlast  in  DATA_W, 2, 1  downstream R fields
grant_id  out  $clog2(NUM_MASTERS)  current/last granted requester
busy  out  1  state != IDLE
rlast_err  out  1  one-cycle pulse on RLAST mismatch

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; grant_id=0; all valid/ready outputs, busy and rlast_err = 0; registered AR fields = 0.
- States: IDLE, ADDR, DATA (plus ERR under macro).
- IDLE:
  - g = first i with s_arvalid[i], scanning from rr_ptr upward modulo NUM_MASTERS.
  - s_arready[g]=1 combinationally in the same cycle; all other s_arready = 0.
  - Capture g's addr/len/size/burst into registers; grant_id<=g; beat counter<=0; ->ADDR.
- ADDR:
  - m_arvalid=1 with registered fields, held stable until m_arready.
  - On m_arready -> DATA.
  - Latency: accept at cycle 0, m_arvalid high at cycle 1.
- DATA:
  - s_rvalid[grant_id]=m_rvalid; other s_rvalid = 0.
  - m_rready=s_rready[grant_id].
  - s_rdata/s_rresp/s_rlast pass through combinationally.
  - Each accepted beat increments the counter.
  - Exit on the accepted beat with m_rlast=1 -> IDLE; rr_ptr<=(grant_id+1) mod NUM_MASTERS.
- RLAST check:
  - If m_rlast on a beat with counter != len, or counter == len without m_rlast: rlast_err pulses 1 cycle.
  - Routing continues until m_rlast in both cases.
- Minimum one IDLE cycle between bursts.
- s_arready is never asserted outside IDLE.
- A requester dropping s_arvalid before grant is legal; it is skipped.
- len=0 burst: single beat with rlast.
- Reset mid-burst: immediate return to IDLE; in-flight beats are abandoned (downstream is reset too).

Optional Feature:
- Macro: AXI4_RD_ARB_BURST_CHECK_EN.
- When defined, the captured request is checked in the IDLE->next transition. It is illegal if any of:
  - burst==3
  - WRAP with len not in {1,3,7,15}
  - FIXED with len>15
  - size > log2(DATA_W/8)
  - INCR where addr[11:0] + ((len+1)<<size) > 4096
- Illegal requests go to ERR instead of ADDR:
  - No m_arvalid is issued.
  - Local beats to the requester: s_rvalid[g]=1, s_rresp=SLVERR, s_rdata=0, s_rlast on beat len, advancing on s_rready.
  - Then ->IDLE with rr_ptr update.
- When undefined: no check; all requests are forwarded unmodified and the ERR state is not built.

Test Plan:
- Reset with all inputs idle -> all outputs 0, grant_id=0, busy=0; assert rst mid-DATA -> s_rvalid=0, busy=0 in the same cycle.
- Requester 2 reads addr 0x1000, len=3, size=3, INCR; m_arready=1 -> m_arvalid at cycle 1 with fields matched; 4 beats to s_rvalid[2] only, s_rlast on 4th; return to IDLE.
- Requesters 0,1,3 all valid continuously, len=0 each -> grant order 0,1,3,0,1,3; each burst grants exactly one s_arready pulse.
- m_arready held low 3 cycles -> m_arvalid and fields stable 4 cycles; s_rready[g] low 2 cycles mid-burst -> m_rready low, no beat lost or duplicated.
- len=3 with m_rlast on beat 2 -> rlast_err pulses once; routing ends at that beat.
- Macro defined: INCR addr 0x0FF8, len=1, size=3 (crosses 4KB) -> no m_arvalid; 2 SLVERR beats, rdata=0, rlast on 2nd. Macro undefined: same request forwarded.
